// File: rtl/nco_mix_decim.sv
// nco_mix_decim: mixes each ADC sample with the NCO sine, then integrates-and-dumps
// DEC products into one decimated baseband sample.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   clken               pipeline clock enable (shared with the NCO)
//   enable              mixer run enable (IDLE <-> RUN)
//   nco_sin, nco_valid  signed NCO sample and its strobe
//   adc_data, adc_valid signed ADC sample and its strobe
//   dout, dout_valid    decimated signed result, valid/ready source side
//   dout_ready          downstream accepts dout
//   overrun             sticky: a dump was dropped under backpressure
//   busy                FSM is in RUN
module nco_mix_decim #(
    parameter int unsigned MPR     = 13,
    parameter int unsigned ADW     = 14,
    parameter int unsigned DEC     = 16,
    parameter int unsigned LOG2DEC = 4,
    parameter int unsigned OW      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clken,
    input  logic                  enable,
    input  logic signed [MPR-1:0] nco_sin,
    input  logic                  nco_valid,
    input  logic signed [ADW-1:0] adc_data,
    input  logic                  adc_valid,
    output logic signed [OW-1:0]  dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  overrun,
    output logic                  busy
);

    localparam int unsigned PW = MPR + ADW;
    localparam int unsigned AW = PW + LOG2DEC;
    localparam logic [LOG2DEC-1:0] CountMax = LOG2DEC'(DEC - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e               state_q;
    logic signed [PW-1:0] prod_q;
    logic                 prod_vld_q;
    logic signed [AW-1:0] acc_q;
    logic [LOG2DEC-1:0]   count_q;
    logic signed [OW-1:0] dout_q;
    logic                 dout_valid_q;
    logic                 overrun_q;

    logic signed [PW-1:0] nco_ext;
    logic signed [PW-1:0] adc_ext;
    logic signed [PW-1:0] product;
    logic signed [AW-1:0] acc_final;
    logic                 accept;
    logic                 dump;

    always_comb begin
        // Sign-extend both operands so the multiply is full-precision signed.
        nco_ext   = PW'(nco_sin);
        adc_ext   = PW'(adc_data);
        product   = nco_ext * adc_ext;
        acc_final = acc_q + AW'(prod_q);
        accept    = (state_q == StRun) && enable && nco_valid && adc_valid;
        dump      = clken && (state_q == StRun) && enable && prod_vld_q
                    && (count_q == CountMax);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            prod_q       <= '0;
            prod_vld_q   <= 1'b0;
            acc_q        <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (clken) begin
                unique case (state_q)
                    StIdle: begin
                        prod_vld_q <= 1'b0;
                        acc_q      <= '0;
                        count_q    <= '0;
                        if (enable) state_q <= StRun;
                    end
                    StRun: begin
                        if (!enable) begin
                            // Abort: drop the partial frame, nothing is emitted.
                            state_q    <= StIdle;
                            prod_vld_q <= 1'b0;
                            acc_q      <= '0;
                            count_q    <= '0;
                        end else begin
                            prod_vld_q <= accept;
                            if (accept) prod_q <= product;
                            if (prod_vld_q) begin
                                if (count_q == CountMax) begin
                                    acc_q   <= '0;
                                    count_q <= '0;
                                end else begin
                                    acc_q   <= acc_final;
                                    count_q <= count_q + 1'b1;
                                end
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end

            // Output side runs every cycle; a dump only lands when the slot is free
            // or is being emptied on this same edge.
            if (dump) begin
                if (!dout_valid_q || dout_ready) begin
                    dout_q       <= acc_final[AW-1:AW-OW];
                    dout_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (dout_valid_q && dout_ready) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q == StRun);

endmodule

// File: tb/tb_nco_mix_decim.sv
module tb_nco_mix_decim;

    logic               clk = 1'b0;
    logic               reset;
    logic               clken;
    logic               enable;
    logic signed [12:0] nco_sin;
    logic               nco_valid;
    logic signed [13:0] adc_data;
    logic               adc_valid;
    logic signed [15:0] dout;
    logic               dout_valid;
    logic               dout_ready;
    logic               overrun;
    logic               busy;

    int errors = 0;
    int checks = 0;

    nco_mix_decim dut (
        .clk        (clk),
        .reset      (reset),
        .clken      (clken),
        .enable     (enable),
        .nco_sin    (nco_sin),
        .nco_valid  (nco_valid),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed=still running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Leave RUN (flushing any partial frame), then re-enter RUN.
    task automatic restart();
        enable    = 1'b0;
        nco_valid = 1'b0;
        adc_valid = 1'b0;
        tick();
        enable = 1'b1;
        tick();
    endtask

    // 16 accepts of adc*sin, then one idle edge on which the dump happens.
    task automatic frame(input int adc, input int sin);
        adc_data  = 14'(adc);
        nco_sin   = 13'(sin);
        nco_valid = 1'b1;
        adc_valid = 1'b1;
        repeat (16) tick();
        nco_valid = 1'b0;
        adc_valid = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; clken = 1'b1; enable = 1'b0;
        nco_sin = '0; nco_valid = 1'b0; adc_data = '0; adc_valid = 1'b0;
        dout_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);

        // Constant mix, streaming continuously
        enable = 1'b1; adc_data = 14'sd1000; nco_sin = 13'sd4095;
        nco_valid = 1'b1; adc_valid = 1'b1;
        tick();
        chk("busy_run", busy, 1);
        repeat (16) tick();
        chk("const_not_yet", dout_valid, 0);
        tick();
        chk("const_valid1", dout_valid, 1);
        chk("const_dout1", dout, 1999);
        repeat (15) tick();
        chk("const_gap", dout_valid, 0);
        tick();
        chk("const_valid2", dout_valid, 1);
        chk("const_dout2", dout, 1999);

        // Sign and floor
        restart();
        frame(-1000, 4095);
        chk("neg_dout", dout, -2000);
        restart();
        frame(-8192, -4096);
        chk("maxmag_dout", dout, 16384);

        // Gaps on adc_valid plus a 3-cycle clken hold with a product pending
        restart();
        adc_data = 14'sd1000; nco_sin = 13'sd4095; nco_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i == 9) begin
                clken = 1'b0; adc_valid = 1'b1;
                repeat (3) tick();
                clken = 1'b1;
            end
            adc_valid = (i % 2 == 0);
            if (i == 31) chk("gap_not_yet", dout_valid, 0);
            tick();
        end
        chk("gap_valid", dout_valid, 1);
        chk("gap_dout", dout, 1999);
        nco_valid = 1'b0; adc_valid = 1'b0;
        tick();
        chk("gap_no_extra", dout_valid, 0);

        // Backpressure across two dumps
        restart();
        dout_ready = 1'b0;
        frame(1000, 4095);
        chk("bp_dout1", dout, 1999);
        chk("bp_overrun0", overrun, 0);
        frame(500, 4095);
        chk("bp_hold_dout", dout, 1999);
        chk("bp_hold_valid", dout_valid, 1);
        chk("bp_overrun1", overrun, 1);
        dout_ready = 1'b1;
        tick();
        chk("bp_drained", dout_valid, 0);
        chk("bp_sticky", overrun, 1);

        // Abort after 7 accepts
        restart();
        adc_data = 14'sd1000; nco_sin = 13'sd4095; nco_valid = 1'b1; adc_valid = 1'b1;
        repeat (7) tick();
        enable = 1'b0;
        tick();
        chk("abort_idle", busy, 0);
        enable = 1'b1;
        tick();
        chk("abort_no_partial", dout_valid, 0);
        frame(1000, 4095);
        chk("abort_valid", dout_valid, 1);
        chk("abort_dout", dout, 1999);

        // Reset after 9 accepts
        nco_valid = 1'b1; adc_valid = 1'b1;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        chk("mrst_dout", dout, 0);
        chk("mrst_valid", dout_valid, 0);
        chk("mrst_overrun", overrun, 0);
        chk("mrst_busy", busy, 0);
        reset = 1'b0; nco_valid = 1'b0; adc_valid = 1'b0;
        tick();
        frame(1000, 4095);
        chk("mrst_dout_after", dout, 1999);

        // Same-edge transfer and dump
        tick();
        dout_ready = 1'b0;
        frame(-1000, 4095);
        chk("same_first", dout, -2000);
        adc_data = 14'sd1000; nco_valid = 1'b1; adc_valid = 1'b1;
        repeat (16) tick();
        dout_ready = 1'b1; nco_valid = 1'b0; adc_valid = 1'b0;
        tick();
        chk("same_dout", dout, 1999);
        chk("same_valid", dout_valid, 1);
        chk("same_overrun", overrun, 0);
        tick();
        chk("same_drained", dout_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
